// File: rtl/uacm_in_framer_pkg.sv
// uacm_in_framer shared definitions.
// Defaults and small types used by the framer and its bench.
package uacm_in_framer_pkg;

  localparam int          DEF_MAX_PKT   = 64;
  localparam logic [7:0]  DEF_TERM_CHAR = 8'h0A;
  localparam int          DEF_TIMEOUT   = 4095;
  localparam int          POS_W         = 6;
  localparam int          IDLE_W        = 12;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } hold_t;

  function automatic pos_t pos_next(input logic last,
                                    input pos_t pos);
    return last ? '0 : pos + 1'b1;
  endfunction

endpackage

// File: rtl/uacm_in_framer_idle_timer.sv
// Saturating idle counter for the in-path framer.
// expired is high while the count sits at a non-zero LIMIT.
module uacm_in_framer_idle_timer #(
  parameter int W     = 12,
  parameter int LIMIT = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [W-1:0] cnt;

  // count while running, hold at LIMIT, clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && cnt != W'(LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (LIMIT != 0) && (cnt == W'(LIMIT));

endmodule

// File: rtl/uacm_in_framer.sv
// Device-to-host packet framer: hold reg H feeds output reg O,
// last on max size, terminator byte or idle timeout.
module uacm_in_framer
  import uacm_in_framer_pkg::*;
#(
  parameter int         MAX_PKT   = DEF_MAX_PKT,
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_CHAR = DEF_TERM_CHAR,
  parameter int         TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       o_valid,
  input  logic       o_ready,
  output logic       to_pulse
);

  hold_t h;
  pos_t  pos;
  logic  o_free;
  logic  term_hit;
  logic  max_hit;
  logic  expired;
  logic  close;
  logic  promote;
  logic  load;

  assign o_free   = ~o_valid | o_ready;
  assign term_hit = TERM_EN && (h.data == TERM_CHAR);
  assign max_hit  = (pos == POS_W'(MAX_PKT - 1));
  assign close    = term_hit | max_hit | expired;
  assign promote  = h.valid & o_free & (i_valid | close);
  assign i_ready  = ~h.valid | promote;
  assign load     = i_valid & i_ready;
  assign to_pulse = promote & expired & ~term_hit & ~max_hit;

  uacm_in_framer_idle_timer #(
    .W     (IDLE_W),
    .LIMIT (TIMEOUT)
  ) u_idle (
    .clk     (clk),
    .rst     (rst),
    .clear   (load | ~h.valid),
    .run     (h.valid),
    .expired (expired)
  );

  // hold register: refill on accept, empty on promote
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
    end else if (load) begin
      h.data  <= i_data;
      h.valid <= 1'b1;
    end else if (promote) begin
      h.valid <= 1'b0;
    end
  end

  // output register: load from H, drop valid once consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data  <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
    end else if (promote) begin
      o_data  <= h.data;
      o_last  <= close;
      o_valid <= 1'b1;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

  // byte index within the packet, restarts after last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (promote) begin
      pos <= pos_next(close, pos);
    end
  end

endmodule

// File: tb/tb_uacm_in_framer.sv
// Directed bench for uacm_in_framer.
// Three instances: terminator+TIMEOUT=8, no terminator, TIMEOUT=0.
module tb_uacm_in_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;

  logic       a_i_ready, a_o_last, a_o_valid, a_to_pulse;
  logic [7:0] a_o_data;
  logic       b_i_ready, b_o_last, b_o_valid, b_to_pulse;
  logic [7:0] b_o_data;
  logic       c_i_ready, c_o_last, c_o_valid, c_to_pulse;
  logic [7:0] c_o_data;

  always #5 clk = ~clk;

  uacm_in_framer #(
    .MAX_PKT(64), .TERM_EN(1'b1), .TERM_CHAR(8'h0A), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_ready(a_i_ready), .o_data(a_o_data), .o_last(a_o_last),
    .o_valid(a_o_valid), .o_ready(o_ready), .to_pulse(a_to_pulse)
  );

  uacm_in_framer #(
    .MAX_PKT(64), .TERM_EN(1'b0), .TERM_CHAR(8'h0A), .TIMEOUT(8)
  ) dut_b (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_ready(b_i_ready), .o_data(b_o_data), .o_last(b_o_last),
    .o_valid(b_o_valid), .o_ready(o_ready), .to_pulse(b_to_pulse)
  );

  uacm_in_framer #(
    .MAX_PKT(64), .TERM_EN(1'b1), .TERM_CHAR(8'h0A), .TIMEOUT(0)
  ) dut_c (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
    .i_ready(c_i_ready), .o_data(c_o_data), .o_last(c_o_last),
    .o_valid(c_o_valid), .o_ready(o_ready), .to_pulse(c_to_pulse)
  );

  int         sel;
  logic       s_i_ready, s_o_last, s_o_valid, s_to_pulse;
  logic [7:0] s_o_data;

  always_comb begin
    s_i_ready  = a_i_ready;
    s_o_last   = a_o_last;
    s_o_valid  = a_o_valid;
    s_to_pulse = a_to_pulse;
    s_o_data   = a_o_data;
    case (sel)
      1: begin
        s_i_ready  = b_i_ready;
        s_o_last   = b_o_last;
        s_o_valid  = b_o_valid;
        s_to_pulse = b_to_pulse;
        s_o_data   = b_o_data;
      end
      2: begin
        s_i_ready  = c_i_ready;
        s_o_last   = c_o_last;
        s_o_valid  = c_o_valid;
        s_to_pulse = c_to_pulse;
        s_o_data   = c_o_data;
      end
      default: ;
    endcase
  end

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] od[$];
  logic       ol[$];
  int         ot[$];
  int         pulses;
  int         pulse_t;

  task automatic clear_log();
    od.delete();
    ol.delete();
    ot.delete();
    pulses  = 0;
    pulse_t = -1;
  endtask

  task automatic snap(input int t);
    if (s_o_valid && o_ready) begin
      od.push_back(s_o_data);
      ol.push_back(s_o_last);
      ot.push_back(t);
    end
    if (s_to_pulse) begin
      pulses++;
      pulse_t = t;
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel     = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    o_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_ready: got %b want 1", s_i_ready);
    end
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_o_valid: got %b want 0", s_o_valid);
    end
    checks++;
    if (s_o_last !== 1'b0 || s_o_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_o_bits: got last=%b data=%h want 0/00",
               s_o_last, s_o_data);
    end
    checks++;
    if (s_to_pulse !== 1'b0 || s_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_pulse_ready: got pulse=%b rdy=%b want 0/1",
               s_to_pulse, s_i_ready);
    end
    next_edge();
  endtask

  task automatic test_stream();
    int bubbles = 0;
    sel = 0;
    do_reset();
    clear_log();
    for (int t = 0; t < 40; t++) begin
      i_valid = (t < 16);
      i_data  = (t < 16) ? 8'(8'h41 + t) : 8'h00;
      @(negedge clk);
      if (t < 16 && s_i_ready !== 1'b1) bubbles++;
      snap(t);
      next_edge();
    end
    i_valid = 1'b0;
    checks++;
    if (bubbles != 0) begin
      failures++;
      $display("FAIL stream_bubbles: got %0d want 0", bubbles);
    end
    checks++;
    if (od.size() != 16) begin
      failures++;
      $display("FAIL stream_count: got %0d want 16", od.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (od[k] !== 8'(8'h41 + k) || ol[k] !== (k == 15)) begin
          failures++;
          $display("FAIL stream_byte%0d: got %h/%b want %h/%b",
                   k, od[k], ol[k], 8'(8'h41 + k), (k == 15));
        end
      end
      checks++;
      if (ot[0] != 2 || ot[14] != 16 || ot[15] != 25) begin
        failures++;
        $display("FAIL stream_timing: got %0d,%0d,%0d want 2,16,25",
                 ot[0], ot[14], ot[15]);
      end
    end
    checks++;
    if (pulses != 1 || pulse_t != 24) begin
      failures++;
      $display("FAIL stream_pulse: got n=%0d t=%0d want 1/24",
               pulses, pulse_t);
    end
  endtask

  task automatic test_max_pkt();
    int bubbles = 0;
    int nl = 0;
    int lpos[3] = '{-1, -1, -1};
    sel = 1;
    do_reset();
    clear_log();
    for (int t = 0; t < 160; t++) begin
      i_valid = (t < 130);
      i_data  = 8'h55;
      @(negedge clk);
      if (t < 130 && s_i_ready !== 1'b1) bubbles++;
      snap(t);
      next_edge();
    end
    i_valid = 1'b0;
    foreach (ol[k]) begin
      if (ol[k]) begin
        if (nl < 3) lpos[nl] = k;
        nl++;
      end
    end
    checks++;
    if (bubbles != 0) begin
      failures++;
      $display("FAIL max_bubbles: got %0d want 0", bubbles);
    end
    checks++;
    if (od.size() != 130) begin
      failures++;
      $display("FAIL max_count: got %0d want 130", od.size());
    end
    checks++;
    if (nl != 3 || lpos[0] != 63 || lpos[1] != 127 || lpos[2] != 129) begin
      failures++;
      $display("FAIL max_lasts: got n=%0d at %0d,%0d,%0d want 3 at 63,127,129",
               nl, lpos[0], lpos[1], lpos[2]);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL max_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_term();
    logic [7:0] msg[6] = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0A};
    logic       exl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    sel = 0;
    do_reset();
    clear_log();
    for (int t = 0; t < 16; t++) begin
      i_valid = (t < 6);
      i_data  = (t < 6) ? msg[t] : 8'h00;
      @(negedge clk);
      snap(t);
      next_edge();
    end
    i_valid = 1'b0;
    checks++;
    if (od.size() != 6) begin
      failures++;
      $display("FAIL term_count: got %0d want 6", od.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (od[k] !== msg[k] || ol[k] !== exl[k]) begin
          failures++;
          $display("FAIL term_byte%0d: got %h/%b want %h/%b",
                   k, od[k], ol[k], msg[k], exl[k]);
        end
      end
      checks++;
      if (ot[0] != 2 || ot[5] != 7) begin
        failures++;
        $display("FAIL term_latency: got %0d,%0d want 2,7", ot[0], ot[5]);
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL term_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_stall();
    logic [7:0] pend[$];
    logic [7:0] exd[3] = '{8'h61, 8'h62, 8'h63};
    logic       exl[3] = '{1'b0, 1'b1, 1'b1};
    int         ext[3] = '{22, 23, 32};
    int         stall_err = 0;
    logic       acc;
    sel = 0;
    do_reset();
    clear_log();
    pend = '{8'h61, 8'h62, 8'h63};
    for (int t = 0; t < 40; t++) begin
      o_ready = (t >= 22);
      i_valid = (pend.size() > 0);
      i_data  = (pend.size() > 0) ? pend[0] : 8'h00;
      @(negedge clk);
      if (t >= 2 && t < 22) begin
        if (s_i_ready !== 1'b0 || s_o_valid !== 1'b1 ||
            s_o_data !== 8'h61 || s_o_last !== 1'b0)
          stall_err++;
      end
      acc = i_valid && s_i_ready;
      snap(t);
      next_edge();
      if (acc) void'(pend.pop_front());
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    checks++;
    if (stall_err != 0) begin
      failures++;
      $display("FAIL stall_hold: got %0d bad cycles want 0", stall_err);
    end
    checks++;
    if (pend.size() != 0) begin
      failures++;
      $display("FAIL stall_accept: got %0d left want 0", pend.size());
    end
    checks++;
    if (od.size() != 3) begin
      failures++;
      $display("FAIL stall_count: got %0d want 3", od.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (od[k] !== exd[k] || ol[k] !== exl[k] || ot[k] != ext[k]) begin
          failures++;
          $display("FAIL stall_byte%0d: got %h/%b@%0d want %h/%b@%0d",
                   k, od[k], ol[k], ot[k], exd[k], exl[k], ext[k]);
        end
      end
    end
    checks++;
    if (pulses != 2 || pulse_t != 31) begin
      failures++;
      $display("FAIL stall_pulses: got n=%0d t=%0d want 2/31",
               pulses, pulse_t);
    end
  endtask

  task automatic test_reset_mid();
    int nl = 0;
    int lp = -1;
    sel = 0;
    do_reset();
    clear_log();
    o_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      i_valid = 1'b1;
      i_data  = 8'(8'h71 + t);
      next_edge();
    end
    i_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    checks++;
    if (s_o_valid !== 1'b0 || s_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_during: got v=%b rdy=%b want 0/1",
               s_o_valid, s_i_ready);
    end
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_o_valid !== 1'b0 || s_i_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_after: got v=%b rdy=%b want 0/1",
               s_o_valid, s_i_ready);
    end
    next_edge();
    o_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      i_valid = (t < 64);
      i_data  = 8'h30;
      @(negedge clk);
      snap(t);
      next_edge();
    end
    i_valid = 1'b0;
    foreach (ol[k]) begin
      if (ol[k]) begin
        if (nl == 0) lp = k;
        nl++;
      end
    end
    checks++;
    if (od.size() != 64) begin
      failures++;
      $display("FAIL rstmid_count: got %0d want 64", od.size());
    end else begin
      checks++;
      if (od[0] !== 8'h30) begin
        failures++;
        $display("FAIL rstmid_first: got %h want 30", od[0]);
      end
    end
    checks++;
    if (nl != 1 || lp != 63) begin
      failures++;
      $display("FAIL rstmid_last: got n=%0d at %0d want 1 at 63", nl, lp);
    end
  endtask

  task automatic test_no_timeout();
    int early = 0;
    sel = 2;
    do_reset();
    clear_log();
    for (int t = 0; t < 66; t++) begin
      i_valid = (t == 0 || t == 61);
      i_data  = (t == 0) ? 8'h33 : 8'h34;
      @(negedge clk);
      if (t < 62 && s_o_valid !== 1'b0) early++;
      snap(t);
      next_edge();
    end
    i_valid = 1'b0;
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL noto_early: got %0d valid cycles want 0", early);
    end
    checks++;
    if (od.size() != 1) begin
      failures++;
      $display("FAIL noto_count: got %0d want 1", od.size());
    end else begin
      checks++;
      if (od[0] !== 8'h33 || ol[0] !== 1'b0 || ot[0] != 62) begin
        failures++;
        $display("FAIL noto_byte: got %h/%b@%0d want 33/0@62",
                 od[0], ol[0], ot[0]);
      end
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL noto_pulses: got %0d want 0", pulses);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    sel     = 0;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    o_ready = 1'b1;
    test_reset();
    test_stream();
    test_max_pkt();
    test_term();
    test_stall();
    test_reset_mid();
    test_no_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
